// File: rtl/video_timing_pkg.sv
// Shared timing defaults, bus widths and sequencer state encoding for the
// video frame sequencer and its timing counter.
package video_timing_pkg;

    localparam int DEF_H_SYNC  = 40;
    localparam int DEF_H_BACK  = 220;
    localparam int DEF_H_DISP  = 1280;
    localparam int DEF_H_FRONT = 110;
    localparam int DEF_H_TOTAL = 1650;

    localparam int DEF_V_SYNC  = 5;
    localparam int DEF_V_BACK  = 20;
    localparam int DEF_V_DISP  = 720;
    localparam int DEF_V_FRONT = 5;
    localparam int DEF_V_TOTAL = 750;

    localparam int DEF_ADDR_W  = 20;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } seqState_t;

endpackage

// File: rtl/video_frame_sequencer_if.sv
// Control, pixel-buffer read and filter-side timing signals of the sequencer.
// The sequencer drives through the master modport; the surrounding system
// (buffer and controller) connects through the slave modport.
interface video_frame_sequencer_if #(
    parameter int ADDR_W = video_timing_pkg::DEF_ADDR_W,
    parameter int DATA_W = video_timing_pkg::DEF_DATA_W
);

    logic              start;
    logic              stop;
    logic              continuous;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              pre_img_vsync;
    logic              pre_img_hsync;
    logic              pre_img_valid;
    logic [DATA_W-1:0] pre_img_data;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_cnt;

    modport master (
        input  start, stop, continuous, rd_data,
        output rd_en, rd_addr, pre_img_vsync, pre_img_hsync, pre_img_valid,
               pre_img_data, busy, frame_done, frame_cnt
    );

    modport slave (
        output start, stop, continuous, rd_data,
        input  rd_en, rd_addr, pre_img_vsync, pre_img_hsync, pre_img_valid,
               pre_img_data, busy, frame_done, frame_cnt
    );

endinterface

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical position counters with sync and display-enable decode.
// While run_i is low the counters are held at (0,0), so a frame always begins
// at the origin the cycle after the sequencer becomes active.
module video_timing_cnt
    import video_timing_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic last_o,
    output logic vsync_o,
    output logic hsync_o,
    output logic de_o
);

    // Widths hold the total itself so every boundary compare stays meaningful
    localparam int HW          = $clog2(H_TOTAL + 1);
    localparam int VW          = $clog2(V_TOTAL + 1);
    localparam int H_DE_START  = H_SYNC + H_BACK;
    localparam int H_DE_END    = H_DE_START + H_DISP;
    localparam int V_DE_START  = V_SYNC + V_BACK;
    localparam int V_DE_END    = V_DE_START + V_DISP;

    if (H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) begin : gHCheck
        $error("horizontal timing segments do not add up to H_TOTAL");
    end
    if (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL) begin : gVCheck
        $error("vertical timing segments do not add up to V_TOTAL");
    end

    logic [HW-1:0] hCnt_q, hCnt_d;
    logic [VW-1:0] vCnt_q, vCnt_d;
    logic          hLast, vLast;

    assign hLast = (hCnt_q == HW'(H_TOTAL - 1));
    assign vLast = (vCnt_q == VW'(V_TOTAL - 1));

    // Next position: hold at origin when stopped, else raster-scan with wrap
    always_comb begin
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (!run_i) begin
            hCnt_d = '0;
            vCnt_d = '0;
        end else if (hLast) begin
            hCnt_d = '0;
            vCnt_d = vLast ? '0 : vCnt_q + 1'b1;
        end else begin
            hCnt_d = hCnt_q + 1'b1;
        end
    end

    // Position registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    assign last_o  = hLast & vLast;
    assign vsync_o = (vCnt_q < VW'(V_SYNC));
    assign hsync_o = (hCnt_q < HW'(H_SYNC));
    assign de_o    = (hCnt_q >= HW'(H_DE_START)) && (hCnt_q < HW'(H_DE_END)) &&
                     (vCnt_q >= VW'(V_DE_START)) && (vCnt_q < VW'(V_DE_END));

endmodule

// File: rtl/video_frame_sequencer.sv
// Frame sequencer: runs the raster timing, reads the pixel buffer in display
// order and presents timing plus pixel data to the filter one cycle later,
// aligned with the buffer's read latency. Frames are never cut short; stop
// and single-frame mode take effect at the frame boundary.
module video_frame_sequencer
    import video_timing_pkg::*;
#(
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic                      clk,
    input logic                      rst,
    video_frame_sequencer_if.master  bus
);

    seqState_t         state_q, state_d;
    logic              stopPend_q, stopPend_d;
    logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
    logic              preVsync_q, preVsync_d;
    logic              preHsync_q, preHsync_d;
    logic              preValid_q, preValid_d;
    logic              frameDone_q, frameDone_d;
    logic [15:0]       frameCnt_q, frameCnt_d;
    logic              active, lastPos, frameEnd, vsync, hsync, de, rdEn;

    assign active = (state_q == ACTIVE);

    video_timing_cnt #(
        .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_DISP (H_DISP),
        .H_FRONT(H_FRONT), .H_TOTAL(H_TOTAL),
        .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_DISP (V_DISP),
        .V_FRONT(V_FRONT), .V_TOTAL(V_TOTAL)
    ) uTimingCnt (
        .clk    (clk),
        .rst    (rst),
        .run_i  (active),
        .last_o (lastPos),
        .vsync_o(vsync),
        .hsync_o(hsync),
        .de_o   (de)
    );

    assign rdEn     = de & active;
    assign frameEnd = active & lastPos;

    // Sequencing FSM, sticky stop request and linear read address
    always_comb begin
        state_d    = state_q;
        stopPend_d = stopPend_q;
        rdAddr_d   = rdAddr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = ACTIVE;
                    stopPend_d = bus.stop;
                    rdAddr_d   = '0;
                end
            end
            ACTIVE: begin
                if (bus.stop) begin
                    stopPend_d = 1'b1;
                end
                if (rdEn) begin
                    rdAddr_d = rdAddr_q + 1'b1;
                end
                if (frameEnd) begin
                    stopPend_d = 1'b0;
                    rdAddr_d   = '0;
                    if (!bus.continuous || stopPend_q || bus.stop) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    // One-cycle delayed timing so it lines up with the buffer's read data
    always_comb begin
        preVsync_d  = vsync & active;
        preHsync_d  = hsync & active;
        preValid_d  = rdEn;
        frameDone_d = frameEnd;
        frameCnt_d  = frameCnt_q + {15'd0, frameEnd};
    end

    // All sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            stopPend_q  <= 1'b0;
            rdAddr_q    <= '0;
            preVsync_q  <= 1'b0;
            preHsync_q  <= 1'b0;
            preValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            frameCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stopPend_q  <= stopPend_d;
            rdAddr_q    <= rdAddr_d;
            preVsync_q  <= preVsync_d;
            preHsync_q  <= preHsync_d;
            preValid_q  <= preValid_d;
            frameDone_q <= frameDone_d;
            frameCnt_q  <= frameCnt_d;
        end
    end

    assign bus.rd_en         = rdEn;
    assign bus.rd_addr       = rdAddr_q;
    assign bus.pre_img_vsync = preVsync_q;
    assign bus.pre_img_hsync = preHsync_q;
    assign bus.pre_img_valid = preValid_q;
    assign bus.pre_img_data  = preValid_q ? bus.rd_data : {DATA_W{1'b0}};
    assign bus.busy          = active;
    assign bus.frame_done    = frameDone_q;
    assign bus.frame_cnt     = frameCnt_q;

endmodule
